add_arbiter: RTL
================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameters:
- NUM_REQ, 4, number of requesters.
- FLOAT_DATA_WIDTH, 32, IEEE-754 single-precision operand width.
- ADD_LATENCY, 5, adder latency in enabled clocks.
- TAG_WIDTH, 2, requester index width (log2 NUM_REQ).

REQ-002 SHALL have ports, one clock and synchronous active-high reset:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  NUM_REQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B; same packing.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse; operation consumed.
- add_dataa  out  32  operand A to shared adder.
- add_datab  out  32  operand B to shared adder.
- add_en  out  1  adder clk_en.
- add_aclr  out  1  adder clear; equals rst.
- add_result  in  32  adder result.
- resp_valid  out  NUM_REQ  one-hot, one-cycle pulse; result for requester i.
- resp_data  out  32  sum returned to the requester.
- inflight  out  3  operations issued but not yet responded (0..ADD_LATENCY+1).
- busy  out  1  high when inflight != 0 or gnt != 0.

Function
REQ-003 SHALL share one external pipelined float adder among NUM_REQ requesters, at most one issue per cycle.
REQ-004 Requests are sampled at the rising edge. When requester i wins in cycle T-1, the block SHALL drive gnt[i]=1, add_dataa=req_a[i], add_datab=req_b[i] and add_en=1 in cycle T, all registered.
REQ-005 Arbitration SHALL be round-robin: search starts at pointer p (reset 0) through p+1.. mod NUM_REQ; after a grant to i, p becomes (i+1) mod NUM_REQ; with no grant, p is unchanged.
REQ-006 A requester with gnt high in the current cycle SHALL be ineligible at that edge, so its req_valid in cycle T counts only as a new request; max per-requester issue rate is one per 2 cycles.
REQ-007 Requesters SHALL hold req_valid and operands stable until gnt; the block SHALL NOT drop or duplicate a request.
REQ-008 The block SHALL keep a tag/valid shift register of depth ADD_LATENCY, advancing only on cycles with add_en=1.
REQ-009 add_en SHALL be 1 in any cycle with a grant or any valid entry in the shift register, and 0 otherwise.
REQ-010 For a grant in cycle T, add_result is valid in cycle T+ADD_LATENCY. The block SHALL register it, driving resp_valid[i]=1 and resp_data=add_result in cycle T+ADD_LATENCY+1.
REQ-011 Responses SHALL return in issue order; back-to-back issues yield back-to-back responses.
REQ-012 resp_data SHALL hold its last value when resp_valid=0. add_dataa and add_datab SHALL hold their last values when gnt=0.
REQ-013 inflight SHALL increment on a grant and decrement on a resp_valid; simultaneous grant and response leaves it unchanged. It SHALL never exceed ADD_LATENCY+1.
REQ-014 The block is always ready; there is no response backpressure. Requesters SHALL accept resp_valid unconditionally.
REQ-015 Arithmetic (rounding, NaN, Inf) is entirely the adder's; the block SHALL pass data unmodified.

Reset
REQ-016 With rst=1 at an edge, the block SHALL set gnt, resp_valid, add_en, inflight and busy to 0, set resp_data, add_dataa and add_datab to 0, set p to 0, and clear all shift-register valids.
REQ-017 Reset mid-operation SHALL discard all in-flight operations; no resp_valid for a pre-reset grant SHALL ever appear after reset.
REQ-018 Requests present during reset SHALL be ignored. The first grant is possible in the cycle after the first edge with rst=0.

Verification
REQ-019 Single op: req_valid=0001, a=0x3F800000 (1.0), b=0x40000000 (2.0) -> gnt=0001 in T; resp_valid=0001, resp_data=0x40400000 (3.0) in T+6; inflight 1 during T..T+5.
REQ-020 Fairness: req_valid=1111 held continuously -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; responses follow in the same order, 6 cycles after each grant.
REQ-021 Lone requester: req_valid[2] held high -> gnt[2] on alternate cycles only; p advances to 3 after each grant.
REQ-022 Reset mid-flight: 3 ops granted, rst=1 two cycles later -> no resp_valid for 20 cycles; inflight=0 and busy=0 after reset.
REQ-023 Idle gating: no requests after the last response -> add_en=0 from the cycle after the final shift-register valid leaves; busy=0.
REQ-024 Boundary: +Inf + -Inf and 0x80000000 + 0x00000000 requested by two requesters -> resp_data equals the adder's output bit-for-bit, routed to the correct resp_valid bits.

Source files
------------

// File: rtl/add_arbiter_if.sv
// rtl/add_arbiter_if.sv - requester and shared-adder signal bundle for add_arbiter
interface add_arbiter_if #(
   parameter int NUM_REQ          = 4,
   parameter int FLOAT_DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]                  req_valid;
   logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] req_a;
   logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]                  gnt;
   logic [FLOAT_DATA_WIDTH-1:0]         add_dataa;
   logic [FLOAT_DATA_WIDTH-1:0]         add_datab;
   logic                                add_en;
   logic                                add_aclr;
   logic [FLOAT_DATA_WIDTH-1:0]         add_result;
   logic [NUM_REQ-1:0]                  resp_valid;
   logic [FLOAT_DATA_WIDTH-1:0]         resp_data;
   logic [2:0]                          inflight;
   logic                                busy;

   modport slave (
      input  req_valid, req_a, req_b, add_result,
      output gnt, add_dataa, add_datab, add_en, add_aclr,
             resp_valid, resp_data, inflight, busy
   );

   modport master (
      output req_valid, req_a, req_b, add_result,
      input  gnt, add_dataa, add_datab, add_en, add_aclr,
             resp_valid, resp_data, inflight, busy
   );
endinterface

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin sharing of one pipelined float adder among NUM_REQ requesters
module add_arbiter #(
   parameter int NUM_REQ          = 4,
   parameter int FLOAT_DATA_WIDTH = 32,
   parameter int ADD_LATENCY      = 5,
   parameter int TAG_WIDTH        = 2
) (
   input logic         clk,
   input logic         rst,
   add_arbiter_if.slave bus
);
   localparam int W = FLOAT_DATA_WIDTH;

   logic [TAG_WIDTH-1:0]   rr_ptr;
   logic [TAG_WIDTH-1:0]   ptr_next;
   logic [TAG_WIDTH-1:0]   win_idx;
   logic [TAG_WIDTH-1:0]   cand;
   logic [TAG_WIDTH-1:0]   gnt_idx;
   logic                   win_found;
   logic [NUM_REQ-1:0]     eligible;
   logic [NUM_REQ-1:0]     gnt_q;
   logic [NUM_REQ-1:0]     resp_valid_q;
   logic [W-1:0]           sel_a;
   logic [W-1:0]           sel_b;
   logic [W-1:0]           dataa_q;
   logic [W-1:0]           datab_q;
   logic [W-1:0]           resp_data_q;
   logic [ADD_LATENCY-1:0] sr_valid;
   logic [TAG_WIDTH-1:0]   sr_tag [ADD_LATENCY];
   logic [2:0]             inflight_q;
   logic                   resp_fire;
   logic                   add_en_w;

   // A requester being granted this cycle already had its request consumed.
   assign eligible = bus.req_valid & ~gnt_q;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = TAG_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      ptr_next = (win_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + TAG_WIDTH'(1);
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == TAG_WIDTH'(i)) begin
            sel_a = bus.req_a[i*W +: W];
            sel_b = bus.req_b[i*W +: W];
         end
      end
   end

   // The adder only advances with add_en, which stays high while any op is inside it.
   assign add_en_w  = (|gnt_q) | (|sr_valid);
   assign resp_fire = sr_valid[ADD_LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= '0;
         gnt_q        <= '0;
         gnt_idx      <= '0;
         dataa_q      <= '0;
         datab_q      <= '0;
         sr_valid     <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         inflight_q   <= '0;
         for (int k = 0; k < ADD_LATENCY; k++) sr_tag[k] <= '0;
      end else begin
         gnt_q <= win_found ? (NUM_REQ'(1) << win_idx) : '0;
         if (win_found) begin
            gnt_idx <= win_idx;
            dataa_q <= sel_a;
            datab_q <= sel_b;
            rr_ptr  <= ptr_next;
         end
         if (add_en_w) begin
            sr_valid  <= {sr_valid[ADD_LATENCY-2:0], |gnt_q};
            sr_tag[0] <= gnt_idx;
            for (int k = 1; k < ADD_LATENCY; k++) sr_tag[k] <= sr_tag[k-1];
         end
         resp_valid_q <= resp_fire ? (NUM_REQ'(1) << sr_tag[ADD_LATENCY-1]) : '0;
         if (resp_fire) resp_data_q <= bus.add_result;
         inflight_q <= inflight_q + 3'(win_found) - 3'(resp_fire);
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.add_dataa  = dataa_q;
   assign bus.add_datab  = datab_q;
   assign bus.add_en     = add_en_w;
   assign bus.add_aclr   = rst;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.inflight   = inflight_q;
   assign bus.busy       = (inflight_q != 3'd0) | (|gnt_q);
endmodule
